// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// Optional instruction counter is enabled with CTRL_PERF_CNT_EN (see multicycle_ctrl).
package arm_ctrl_pkg;

    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        MEMWB  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        FAULT  = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    function automatic logic cmd_valid(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Add/sub class commands update all of NZCV; the rest only NZ.
    function automatic logic cmd_arith(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_CMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_CMP: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            CMD_MOV: return ALU_MOV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluation: Cond field against stored NZCV flags.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ok
);

    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Decode the 16 ARM condition codes
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z_s;
            COND_NE: cond_ok = ~z_s;
            COND_CS: cond_ok = c_s;
            COND_CC: cond_ok = ~c_s;
            COND_MI: cond_ok = n_s;
            COND_PL: cond_ok = ~n_s;
            COND_VS: cond_ok = v_s;
            COND_VC: cond_ok = ~v_s;
            COND_HI: cond_ok = c_s & ~z_s;
            COND_LS: cond_ok = ~c_s | z_s;
            COND_GE: cond_ok = (n_s == v_s);
            COND_LT: cond_ok = (n_s != v_s);
            COND_GT: cond_ok = ~z_s & (n_s == v_s);
            COND_LE: cond_ok = z_s | (n_s != v_s);
            COND_AL: cond_ok = 1'b1;
            COND_NV: cond_ok = 1'b0;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the ARM-subset datapath with NZCV flags and memory-timeout trap.
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter on instr_count.
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Cond,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rd,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       flags_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             fault_r;
    logic             cond_ok_s;
    logic             instr_ok_s;
    logic             wait_state_s;
    logic             timeout_s;
    logic [3:0]       cmd_s;
    logic             is_cmp_s;
    logic             rd_pc_s;
    logic [1:0]       imm_dec_s;
    logic [1:0]       regsrc_dec_s;

    assign cmd_s    = Funct[4:1];
    assign is_cmp_s = (cmd_s == CMD_CMP);
    assign rd_pc_s  = (Rd == 4'd15);
    assign fault    = fault_r;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_r),
        .cond_ok (cond_ok_s)
    );

    // Instruction acceptance and memory-wait timeout detection
    always_comb begin
        instr_ok_s   = cond_ok_s &&
                       ((Op == OP_MEM) || (Op == OP_BR) || ((Op == OP_DP) && cmd_valid(cmd_s)));
        wait_state_s = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
        timeout_s    = wait_state_s && !mem_ready && (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1));
    end

    // Immediate format and register-source selects implied by the opcode
    always_comb begin
        imm_dec_s    = IMM_8;
        regsrc_dec_s = 2'b00;
        case (Op)
            OP_DP:   begin imm_dec_s = IMM_8;  regsrc_dec_s = 2'b00;           end
            OP_MEM:  begin imm_dec_s = IMM_12; regsrc_dec_s = {~Funct[0], 1'b0}; end
            OP_BR:   begin imm_dec_s = IMM_24; regsrc_dec_s = 2'b01;           end
            default: begin imm_dec_s = IMM_8;  regsrc_dec_s = 2'b00;           end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FETCH:   state_nxt_s = timeout_s ? FAULT : (mem_ready ? DECODE : FETCH);
            DECODE: begin
                if (!instr_ok_s)        state_nxt_s = FETCH;
                else if (Op == OP_MEM)  state_nxt_s = MEMADR;
                else if (Op == OP_BR)   state_nxt_s = BRANCH;
                else if (Funct[5])      state_nxt_s = EXECI;
                else                    state_nxt_s = EXECR;
            end
            MEMADR:  state_nxt_s = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   state_nxt_s = timeout_s ? FAULT : (mem_ready ? MEMWB : MEMRD);
            MEMWR:   state_nxt_s = timeout_s ? FAULT : (mem_ready ? FETCH : MEMWR);
            MEMWB:   state_nxt_s = FETCH;
            EXECR:   state_nxt_s = ALUWB;
            EXECI:   state_nxt_s = ALUWB;
            ALUWB:   state_nxt_s = FETCH;
            BRANCH:  state_nxt_s = FETCH;
            FAULT:   state_nxt_s = FAULT;
            default: state_nxt_s = FAULT;
        endcase
    end

    // Datapath selects and write enables; everything is forced low while in reset
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_8;
        RegSrc     = 2'b00;
        if (rst) begin
            PCWrite = 1'b0;
        end else begin
            if ((state_r != FETCH) && (state_r != FAULT)) begin
                ImmSrc = imm_dec_s;
                RegSrc = regsrc_dec_s;
            end else begin
                ImmSrc = IMM_8;
            end
            case (state_r)
                FETCH: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                DECODE: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                end
                MEMADR: begin
                    ALUSrcB    = SRCB_EXT;
                    ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
                end
                MEMRD:  AdrSrc = 1'b1;
                MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = mem_ready;
                end
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                    PCWrite   = rd_pc_s;
                end
                EXECR:  ALUControl = cmd_alu(cmd_s);
                EXECI: begin
                    ALUSrcB    = SRCB_EXT;
                    ALUControl = cmd_alu(cmd_s);
                end
                ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = ~is_cmp_s;
                    PCWrite   = rd_pc_s & ~is_cmp_s;
                end
                BRANCH: begin
                    ALUSrcB   = SRCB_EXT;
                    ResultSrc = RES_ALU;
                    PCWrite   = 1'b1;
                end
                default: PCWrite = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= FETCH;
        else     state_r <= state_nxt_s;
    end

    // Memory wait counter, restarted on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                wait_cnt_r <= '0;
        else if (state_nxt_s != state_r)       wait_cnt_r <= '0;
        else if (wait_state_s && !mem_ready)   wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        else                                   wait_cnt_r <= wait_cnt_r;
    end

    // Sticky timeout indication, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       fault_r <= 1'b0;
        else if (state_nxt_s == FAULT) fault_r <= 1'b1;
        else                           fault_r <= fault_r;
    end

    // NZCV register; logic ops leave C and V untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (((state_r == EXECR) || (state_r == EXECI)) && Funct[0]) begin
            if (cmd_arith(cmd_s)) flags_r <= ALUFlags;
            else                  flags_r <= {ALUFlags[3:2], flags_r[1:0]};
        end else begin
            flags_r <= flags_r;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count_r;
    logic        retire_s;

    // An instruction retires when a completing state hands back to FETCH
    always_comb begin
        retire_s = (state_nxt_s == FETCH) &&
                   ((state_r == MEMWB) || (state_r == MEMWR) ||
                    (state_r == ALUWB) || (state_r == BRANCH));
    end

    // Retired-instruction counter, free-running modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           instr_count_r <= 32'd0;
        else if (retire_s) instr_count_r <= instr_count_r + 32'd1;
        else               instr_count_r <= instr_count_r;
    end

    assign instr_count = instr_count_r;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction cycle-list model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Cond, Rd, ALUFlags;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, fault;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instr_count;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [4:0]  EN_FLT = 5'b10000, EN_PC = 5'b01000, EN_IR = 5'b00100,
                            EN_RW  = 5'b00010, EN_MW = 5'b00001;
    localparam logic [12:0] M_ADR = 13'h1000, M_RES = 13'h0C00, M_SRCA = 13'h0200,
                            M_SRCB = 13'h0180, M_ALUC = 13'h0070, M_IMM = 13'h000C,
                            M_RS = 13'h0003, M_ALL = 13'h1FFF;

    typedef struct {
        logic        mr;
        logic [3:0]  af;
        logic [4:0]  en;
        logic [12:0] sel;
        logic [12:0] msk;
    } step_t;

    step_t       q[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  m_flags;
    int unsigned m_count;
    string       cur_tag;

    logic [4:0]  obs_en;
    logic [12:0] obs_sel;
    assign obs_en  = {fault, PCWrite, IRWrite, RegWrite, MemWrite};
    assign obs_sel = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] pk(input logic adr, input logic [1:0] res, input logic srca,
                                       input logic [1:0] srcb, input logic [2:0] aluc,
                                       input logic [1:0] imm, input logic [1:0] rs);
        return {adr, res, srca, srcb, aluc, imm, rs};
    endfunction

    // Odd codes are the negation of the even code below them; AL always, NV never.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    function automatic int alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b1010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b1101: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef CTRL_PERF_CNT_EN
        return m_count;
`else
        return m_count & 32'd0;
`endif
    endfunction

    task automatic add(input logic mr, input logic [3:0] af, input logic [4:0] en,
                       input logic [12:0] sel, input logic [12:0] msk);
        step_t s;
        s.mr = mr; s.af = af; s.en = en; s.sel = sel; s.msk = msk;
        q.push_back(s);
    endtask

    // Each step: drive at posedge+1, compare at negedge
    task automatic play();
        int n = 0;
        while (q.size() > 0) begin
            step_t s = q.pop_front();
            mem_ready = s.mr;
            ALUFlags  = s.af;
            @(negedge clk);
            chk($sformatf("%s en c%0d", cur_tag, n), 32'(obs_en), 32'(s.en));
            if (s.msk != 13'h0)
                chk($sformatf("%s sel c%0d", cur_tag, n), 32'(obs_sel & s.msk), 32'(s.sel & s.msk));
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, " rst en"}, 32'(obs_en), 32'd0);
        chk({tag, " rst sel"}, 32'(obs_sel), 32'd0);
        chk({tag, " rst cnt"}, instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_flags = 4'b0000;
        m_count = 0;
    endtask

    // Build the expected cycle list of one instruction from its fields, then replay it.
    task automatic run_instr(input string tag, input logic [31:0] ins, input int fw,
                             input int mw, input logic [3:0] xaf, input int keep);
        logic [3:0] c, rd, cmd;
        logic [1:0] op;
        logic [5:0] f;
        logic       ok;
        logic [1:0] imm, rs;
        int         a;
        c = ins[31:28]; op = ins[27:26]; f = ins[25:20]; rd = ins[15:12]; cmd = f[4:1];
        cur_tag = tag;
        chk({tag, " count"}, instr_count, exp_count());
        Cond = c; Op = op; Funct = f; Rd = rd;
        for (int i = 0; i < fw; i++)
            add(1'b0, 4'($urandom), 5'd0, pk(0, 2'b10, 1, 2'b10, 0, 0, 0), M_ADR | M_RES | M_SRCA | M_SRCB);
        add(1'b1, 4'($urandom), EN_PC | EN_IR, pk(0, 2'b10, 1, 2'b10, 0, 0, 0), M_ADR | M_RES | M_SRCA | M_SRCB);
        a  = alu_of(cmd);
        ok = cond_holds(c, m_flags) && (op != 2'b11) && ((op != 2'b00) || (a >= 0));
        imm = (op == 2'b01) ? 2'b01 : ((op == 2'b10) ? 2'b10 : 2'b00);
        rs  = (op == 2'b10) ? 2'b01 : (((op == 2'b01) && !f[0]) ? 2'b10 : 2'b00);
        add(1'($urandom), 4'($urandom), 5'd0, pk(0, 0, 1, 2'b10, 0, imm, rs),
            M_SRCA | M_SRCB | ((op != 2'b11) ? (M_IMM | M_RS) : 13'h0));
        if (ok && op == 2'b10) begin
            add(1'($urandom), 4'($urandom), EN_PC, pk(0, 2'b10, 0, 2'b01, 0, 2'b10, 2'b01),
                M_RES | M_SRCA | M_SRCB | M_IMM | M_RS);
            m_count++;
        end else if (ok && op == 2'b01) begin
            add(1'($urandom), 4'($urandom), 5'd0, pk(0, 0, 0, 2'b01, f[3] ? 3'd0 : 3'd1, 2'b01, 0),
                M_SRCB | M_ALUC | M_IMM);
            for (int i = 0; i < mw; i++)
                add(1'b0, 4'($urandom), 5'd0, pk(1, 0, 0, 0, 0, 0, 0), M_ADR);
            if (f[0]) begin
                add(1'b1, 4'($urandom), 5'd0, pk(1, 0, 0, 0, 0, 0, 0), M_ADR);
                add(1'($urandom), 4'($urandom), EN_RW | ((rd == 4'd15) ? EN_PC : 5'd0),
                    pk(0, 2'b01, 0, 0, 0, 0, 0), M_RES);
            end else begin
                add(1'b1, 4'($urandom), EN_MW, pk(1, 0, 0, 0, 0, 0, 0), M_ADR);
            end
            m_count++;
        end else if (ok) begin
            add(1'($urandom), xaf, 5'd0, pk(0, 0, 0, f[5] ? 2'b01 : 2'b00, 3'(a), 0, 0), M_SRCB | M_ALUC);
            if (f[0]) m_flags = (a <= 1) ? xaf : {xaf[3:2], m_flags[1:0]};
            add(1'($urandom), 4'($urandom),
                (cmd == 4'b1010) ? 5'd0 : (EN_RW | ((rd == 4'd15) ? EN_PC : 5'd0)),
                pk(0, 2'b00, 0, 0, 0, 0, 0), M_RES);
            m_count++;
        end
        if (keep > 0)
            while (q.size() > keep) void'(q.pop_back());
        play();
    endtask

    task automatic run_timeout();
        cur_tag = "timeout";
        Cond = 4'hE; Op = 2'b00; Funct = 6'b101000; Rd = 4'd0;
        for (int i = 0; i < 15; i++)
            add(1'b0, 4'($urandom), 5'd0, pk(0, 2'b10, 1, 2'b10, 0, 0, 0), M_ADR | M_RES | M_SRCA | M_SRCB);
        for (int i = 0; i < 5; i++)
            add(1'($urandom), 4'($urandom), EN_FLT, 13'h0, 13'h0);
        play();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] cmds [6];
        logic [3:0] c, rd;
        logic [1:0] op;
        logic [5:0] f;
        cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};
        rst = 1'b1; mem_ready = 1'b0; ALUFlags = 4'h0;
        Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0;
        m_flags = 4'b0000; m_count = 0;
        @(posedge clk);
        #1;
        do_reset("init");

        run_instr("add_imm", 32'he2800004, 0, 0, 4'($urandom), 0);
        run_instr("cmp_z",   32'he35100ff, 0, 0, 4'b0110, 0);
        run_instr("beq_tk",  32'h0a00003f, 0, 0, 4'h0, 0);
        run_instr("cmp_nz",  32'he35100ff, 0, 0, 4'b0000, 0);
        run_instr("beq_nt",  32'h0a00003f, 0, 0, 4'h0, 0);
        run_instr("ldr_w3",  32'he5901000, 0, 3, 4'h0, 0);
        run_instr("str_w2",  32'he5804000, 0, 2, 4'h0, 0);
        run_instr("b_back",  32'heaffffdf, 0, 0, 4'h0, 0);
        run_instr("fetch14", 32'he2800004, 14, 0, 4'h0, 0);
        run_instr("ldr_w14", 32'he5901000, 0, 14, 4'h0, 0);
        run_instr("ldr_rst", 32'he5901000, 0, 6, 4'h0, 4);
        do_reset("mid_memrd");
        run_instr("after_rst", 32'he2800004, 0, 0, 4'h0, 0);

        for (int k = 0; k < 150; k++) begin
            c  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if (op == 2'b00 && $urandom_range(0, 7) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
            rd = 4'($urandom_range(0, 15));
            run_instr($sformatf("rnd%0d", k), {c, op, f, 4'h0, rd, 12'h0},
                      $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom), 0);
        end

        run_instr("pre_flt", 32'he2800004, 0, 0, 4'h0, 0);
        run_timeout();
        do_reset("post_flt");
        run_instr("recover", 32'heaffffdf, 0, 0, 4'h0, 0);
        cur_tag = "final";
        chk("final count", instr_count, exp_count());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
